keypad_entry_ctrl: RTL and testbench

Sequences keypad key events into a two-digit hex entry and time-multiplexes the two digits onto one shared seven-segment decoder. It sits between the keypad row scanner and the display datapath. It accepts exactly one digit per physical press and locks out further events until the key has been released and debounced. It owns the shared-decoder schedule: which digit is driven, and which anode is enabled, on every cycle.

---
 rtl/keypad_entry_ctrl_if.sv | 26 ++
 rtl/keypad_entry_ctrl.sv | 88 ++++++++
 tb/tb_keypad_entry_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: scanner-side inputs and display-side outputs of keypad_entry_ctrl
//   key_en, key_row, col            : row scanner -> controller
//   digit_left, digit_right         : entered digits (older, newest)
//   new_digit, reject, held         : entry status pulses/level
//   seg_digit, an_left, an_right    : shared seven-segment decoder drive
interface keypad_entry_ctrl_if;
    logic       key_en;
    logic [3:0] key_row;
    logic [3:0] col;
    logic [3:0] digit_left;
    logic [3:0] digit_right;
    logic       new_digit;
    logic       reject;
    logic       held;
    logic [3:0] seg_digit;
    logic       an_left;
    logic       an_right;
    modport master (
        output key_en, key_row, col,
        input  digit_left, digit_right, new_digit, reject, held, seg_digit, an_left, an_right
    );
    modport slave (
        input  key_en, key_row, col,
        output digit_left, digit_right, new_digit, reject, held, seg_digit, an_left, an_right
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: one digit per key press into a two-digit entry, multiplexed onto one decoder
//   clk   : scan/system clock
//   reset : asynchronous, active-low
//   kp    : slave side of keypad_entry_ctrl_if (scanner inputs, digit/status/display outputs)
module keypad_entry_ctrl #(
    parameter int RELEASE_CYCLES = 8,
    parameter int MUX_DIV        = 1
) (
    input logic                clk,
    input logic                reset,
    keypad_entry_ctrl_if.slave kp
);
    typedef enum logic {IDLE, HOLD} state_t;
    // nibble {row_idx, col_idx} holds the key code; row 0 is the low 16 bits
    localparam logic [63:0] KEY_MAP  = 64'hDF0E_C987_B654_A321;
    localparam logic [7:0]  REL_LAST = 8'(RELEASE_CYCLES - 1);
    localparam logic [7:0]  MUX_LAST = 8'(MUX_DIV - 1);
    state_t     state_q, state_d;
    logic [3:0] left_q, left_d, right_q, right_d;
    logic       new_q, new_d, rej_q, rej_d;
    logic [7:0] rel_cnt_q, rel_cnt_d, mux_cnt_q, mux_cnt_d;
    logic       sel_q, sel_d;
    logic [1:0] r, c;
    logic [3:0] code;
    logic       valid;
    // one-hot to index; only meaningful when valid
    assign r     = {kp.key_row[3] | kp.key_row[2], kp.key_row[3] | kp.key_row[1]};
    assign c     = {kp.col[3] | kp.col[2], kp.col[3] | kp.col[1]};
    assign code  = KEY_MAP[{r, c, 2'b00} +: 4];
    assign valid = $onehot(kp.key_row) && $onehot(kp.col);
    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        right_d   = right_q;
        new_d     = 1'b0;
        rej_d     = 1'b0;
        rel_cnt_d = rel_cnt_q;
        if (state_q == IDLE) begin
            if (kp.key_en && valid) begin
                left_d    = right_q;
                right_d   = code;
                new_d     = 1'b1;
                state_d   = HOLD;
                rel_cnt_d = '0;
            end else if (kp.key_en) begin
                rej_d = 1'b1;
            end
        end else if (kp.col != 4'd0) begin
            rel_cnt_d = '0;
        end else if (rel_cnt_q == REL_LAST) begin
            state_d   = IDLE;
            rel_cnt_d = '0;
        end else begin
            rel_cnt_d = rel_cnt_q + 8'd1;
        end
        mux_cnt_d = (mux_cnt_q == MUX_LAST) ? 8'd0 : mux_cnt_q + 8'd1;
        sel_d     = sel_q ^ (mux_cnt_q == MUX_LAST);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            left_q    <= '0;
            right_q   <= '0;
            new_q     <= 1'b0;
            rej_q     <= 1'b0;
            rel_cnt_q <= '0;
            mux_cnt_q <= '0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            right_q   <= right_d;
            new_q     <= new_d;
            rej_q     <= rej_d;
            rel_cnt_q <= rel_cnt_d;
            mux_cnt_q <= mux_cnt_d;
            sel_q     <= sel_d;
        end
    end
    assign kp.digit_left  = left_q;
    assign kp.digit_right = right_q;
    assign kp.new_digit   = new_q;
    assign kp.reject      = rej_q;
    assign kp.held        = (state_q == HOLD);
    assign kp.seg_digit   = sel_q ? left_q : right_q;
    assign kp.an_left     = ~sel_q;
    assign kp.an_right    = sel_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed checks of keypad_entry_ctrl with RELEASE_CYCLES=8, MUX_DIV=3
module tb_keypad_entry_ctrl;
    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic       rej;
        logic [3:0] l;
        logic [3:0] r;
    } vec_t;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [3:0] exp_l = 4'h0;
    logic [3:0] exp_r = 4'h0;
    logic       exp_sel;
    keypad_entry_ctrl_if kp ();
    keypad_entry_ctrl #(.RELEASE_CYCLES(8), .MUX_DIV(3)) dut (.clk(clk), .reset(reset), .kp(kp));
    always #5 clk = ~clk;
    // cycles since reset release; the selected digit flips every 3 of them
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end
    assign exp_sel = ((cyc / 3) % 2) == 1;
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic chk_state(input logic nd, input logic rj, input logic hd);
        chk("digit_left", 8'(kp.digit_left), 8'(exp_l));
        chk("digit_right", 8'(kp.digit_right), 8'(exp_r));
        chk("new_digit", 8'(kp.new_digit), 8'(nd));
        chk("reject", 8'(kp.reject), 8'(rj));
        chk("held", 8'(kp.held), 8'(hd));
        chk("seg_digit", 8'(kp.seg_digit), 8'(exp_sel ? exp_l : exp_r));
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("anodes", {6'd0, kp.an_left, kp.an_right}, {6'd0, !exp_sel, exp_sel});
    endtask
    task automatic press(input logic [3:0] row, input logic [3:0] cl);
        kp.key_en = 1'b1;
        kp.key_row = row;
        kp.col = cl;
        tick();
        kp.key_en = 1'b0;
    endtask
    task automatic release_key();
        kp.col = 4'd0;
        repeat (7) begin
            tick();
            chk_state(1'b0, 1'b0, 1'b1);
        end
        tick();
        chk_state(1'b0, 1'b0, 1'b0);
    endtask
    initial begin
        vec_t tbl[8];
        tbl[0] = '{4'b1000, 4'b0010, 1'b0, 4'h0, 4'h0};
        tbl[1] = '{4'b0001, 4'b1000, 1'b0, 4'h0, 4'hA};
        tbl[2] = '{4'b0010, 4'b0110, 1'b1, 4'h0, 4'hA};
        tbl[3] = '{4'b0100, 4'b0001, 1'b0, 4'hA, 4'h7};
        tbl[4] = '{4'b0011, 4'b0001, 1'b1, 4'hA, 4'h7};
        tbl[5] = '{4'b0000, 4'b0001, 1'b1, 4'hA, 4'h7};
        tbl[6] = '{4'b1000, 4'b1000, 1'b0, 4'h7, 4'hD};
        tbl[7] = '{4'b0010, 4'b0010, 1'b0, 4'hD, 4'h5};
        kp.key_en = 1'b0;
        kp.key_row = 4'd0;
        kp.col = 4'd0;
        repeat (3) tick();
        chk_state(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk_state(1'b0, 1'b0, 1'b0);
        // r1/c2 held 20 cycles
        press(4'b0010, 4'b0100);
        exp_r = 4'h6;
        chk_state(1'b1, 1'b0, 1'b1);
        repeat (19) begin
            tick();
            chk_state(1'b0, 1'b0, 1'b1);
        end
        release_key();
        // fresh history, then the vector table
        reset = 1'b0;
        exp_l = 4'h0;
        exp_r = 4'h0;
        tick();
        reset = 1'b1;
        foreach (tbl[i]) begin
            press(tbl[i].row, tbl[i].col);
            exp_l = tbl[i].l;
            exp_r = tbl[i].r;
            chk_state(!tbl[i].rej, tbl[i].rej, !tbl[i].rej);
            if (!tbl[i].rej) begin
                repeat (2) begin
                    tick();
                    chk_state(1'b0, 1'b0, 1'b1);
                end
                release_key();
            end else begin
                kp.col = 4'd0;
                tick();
                chk_state(1'b0, 1'b0, 1'b0);
            end
        end
        // bounce during release with key_en strobes inside HOLD
        press(4'b0001, 4'b0010);
        exp_l = 4'h5;
        exp_r = 4'h2;
        chk_state(1'b1, 1'b0, 1'b1);
        kp.col = 4'd0;
        repeat (5) begin
            tick();
            chk_state(1'b0, 1'b0, 1'b1);
        end
        press(4'b0001, 4'b0010);
        chk_state(1'b0, 1'b0, 1'b1);
        kp.col = 4'd0;
        repeat (7) begin
            tick();
            chk_state(1'b0, 1'b0, 1'b1);
        end
        // key_en on the exit edge is ignored, the next edge accepts
        press(4'b0001, 4'b0000);
        chk_state(1'b0, 1'b0, 1'b0);
        press(4'b0001, 4'b0001);
        exp_l = 4'h2;
        exp_r = 4'h1;
        chk_state(1'b1, 1'b0, 1'b1);
        release_key();
        // async reset mid-HOLD and mid-pulse with digits 5,9
        reset = 1'b0;
        exp_l = 4'h0;
        exp_r = 4'h0;
        tick();
        reset = 1'b1;
        press(4'b0010, 4'b0010);
        exp_r = 4'h5;
        chk_state(1'b1, 1'b0, 1'b1);
        release_key();
        press(4'b0100, 4'b0100);
        exp_l = 4'h5;
        exp_r = 4'h9;
        chk_state(1'b1, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        exp_l = 4'h0;
        exp_r = 4'h0;
        chk_state(1'b0, 1'b0, 1'b0);
        chk("an_right_rst", 8'(kp.an_right), 8'd0);
        chk("an_left_rst", 8'(kp.an_left), 8'd1);
        @(negedge clk);
        kp.col = 4'd0;
        tick();
        chk_state(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        press(4'b0001, 4'b1000);
        exp_r = 4'hA;
        chk_state(1'b1, 1'b0, 1'b1);
        release_key();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
